// File: rtl/rr_select_arbiter.sv
// rr_select_arbiter: round-robin arbiter driving the registered 3-bit select of a 3-to-8 decoder
//   clk     : rising-edge clock
//   rst     : synchronous active-high reset
//   req     : request vector, bit i requests decoder output d<i>
//   done    : owner releases the grant (only honoured while valid=1)
//   x/y/z   : registered select index bits 2/1/0
//   valid   : grant active, qualifies the decoder output
//   timeout : one-cycle pulse on a forced release after MAX_HOLD cycles
module rr_select_arbiter #(
    parameter int MAX_HOLD = 15,
    parameter int CNT_W    = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] req,
    input  logic       done,
    output logic       x,
    output logic       y,
    output logic       z,
    output logic       valid,
    output logic       timeout
);
    typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(MAX_HOLD == 0 ? 0 : MAX_HOLD - 1);

    state_t           state_q;
    logic [2:0]       ptr_q, sel_q, win_d;
    logic [CNT_W-1:0] cnt_q;
    logic             valid_q, timeout_q, hit;

    // Search ptr+1 .. ptr+8 with 3-bit wraparound; the last step revisits ptr itself.
    always_comb begin
        win_d = ptr_q;
        hit   = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            if (!hit && req[3'(ptr_q + 3'(i))]) begin
                hit   = 1'b1;
                win_d = 3'(ptr_q + 3'(i));
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            sel_q     <= 3'd0;
            ptr_q     <= 3'd7;
            cnt_q     <= '0;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= 1'b0;
            case (state_q)
                IDLE: if (hit) begin
                    sel_q   <= win_d;
                    ptr_q   <= win_d;
                    cnt_q   <= '0;
                    valid_q <= 1'b1;
                    state_q <= GRANT;
                end
                GRANT: begin
                    if (cnt_q != '1) cnt_q <= cnt_q + 1'b1;
                    // done and withdrawal outrank the timeout, so the pulse only marks a true forced release
                    if (done || !req[sel_q] || (MAX_HOLD != 0 && cnt_q == LAST)) begin
                        valid_q   <= 1'b0;
                        timeout_q <= !done && req[sel_q];
                        state_q   <= GAP;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign {x, y, z} = sel_q;
    assign valid     = valid_q;
    assign timeout   = timeout_q;
endmodule

// File: tb/tb_rr_select_arbiter.sv
// tb_rr_select_arbiter: self-checking bench for rr_select_arbiter with a behavioural model
module tb_rr_select_arbiter;
    localparam int MAX_HOLD = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] req = 8'h00;
    logic       done = 1'b0;
    logic       x, y, z, valid, timeout;

    int n_checks = 0;
    int n_pass   = 0;

    // behavioural model state
    int         m_last, m_len;
    bit         m_own, m_cool;
    logic [2:0] m_sel;
    logic       m_valid, m_to;

    rr_select_arbiter #(.MAX_HOLD(MAX_HOLD), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .req(req), .done(done),
        .x(x), .y(y), .z(z), .valid(valid), .timeout(timeout)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got running, expected finished");
        $fatal(1);
    end

    // One clock edge as the specification describes it: a grant lasts m_len cycles,
    // one cool-down cycle follows any release, and the search walks last+1 .. last+8 mod 8.
    task automatic model_step();
        if (rst) begin
            m_sel = 3'd0; m_valid = 1'b0; m_to = 1'b0;
            m_last = 7; m_own = 0; m_cool = 0; m_len = 0;
        end else begin
            m_to = 1'b0;
            if (m_own) begin
                if (done || !req[m_sel]) begin
                    m_own = 0; m_cool = 1;
                end else if (MAX_HOLD != 0 && m_len == MAX_HOLD) begin
                    m_own = 0; m_cool = 1; m_to = 1'b1;
                end else m_len++;
            end else if (m_cool) begin
                m_cool = 0;
            end else begin
                for (int k = 1; k <= 8; k++) begin
                    int w;
                    w = (m_last + k) % 8;
                    if (req[w]) begin
                        m_sel = 3'(w); m_last = w; m_own = 1; m_len = 1;
                        break;
                    end
                end
            end
            m_valid = m_own;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic wait_valid(output bit ok);
        ok = 0;
        for (int i = 0; i < 4 && !ok; i++) begin
            tick();
            ok = valid;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; req = 8'h00; done = 1'b0;
        tick(); tick();
        n_checks++;
        if ({x, y, z, valid, timeout} !== 5'b0) $display("FAIL reset: got xyz/v/t=%b expected 00000", {x, y, z, valid, timeout});
        else n_pass++;
        rst = 1'b0;
        tick();
        n_checks++;
        if ({x, y, z, valid, timeout} !== 5'b0) $display("FAIL idle_after_reset: got %b expected 00000", {x, y, z, valid, timeout});
        else n_pass++;
    endtask

    task automatic test_first_grant();
        req = 8'h81;
        tick();
        n_checks++;
        if ({x, y, z, valid} !== 4'b0001) $display("FAIL first_grant: got xyz/v=%b expected 0001", {x, y, z, valid});
        else n_pass++;
        tick();
        done = 1'b1;
        tick();
        done = 1'b0;
        n_checks++;
        if (valid !== 1'b0) $display("FAIL done_release: got valid=%b expected 0", valid);
        else n_pass++;
        tick();
        n_checks++;
        if (valid !== 1'b0) $display("FAIL gap_second_low: got valid=%b expected 0", valid);
        else n_pass++;
        tick();
        n_checks++;
        if ({x, y, z, valid} !== 4'b1111) $display("FAIL second_grant: got xyz/v=%b expected 1111", {x, y, z, valid});
        else n_pass++;
        req = 8'h00;
        tick(); tick();
    endtask

    task automatic test_rotation();
        bit ok;
        int n;
        req = 8'hFF;
        for (int g = 0; g <= 8; g++) begin
            wait_valid(ok);
            n_checks++;
            if (!ok || {x, y, z} !== 3'(g % 8)) $display("FAIL rotation_idx%0d: got valid=%b idx=%0d expected valid=1 idx=%0d", g, valid, {x, y, z}, g % 8);
            else n_pass++;
            n = 1;
            for (int c = 0; c < 2; c++) begin
                tick();
                if (valid) n++;
            end
            done = 1'b1;
            tick();
            done = 1'b0;
            n_checks++;
            if (valid !== 1'b0 || n != 3) $display("FAIL rotation_window%0d: got len=%0d valid_after=%b expected len=3 valid_after=0", g, n, valid);
            else n_pass++;
        end
        req = 8'h00;
        tick();
    endtask

    task automatic test_timeout();
        bit ok;
        int n;
        req = 8'h04;
        wait_valid(ok);
        n_checks++;
        if (!ok || {x, y, z} !== 3'd2) $display("FAIL timeout_grant: got valid=%b idx=%0d expected valid=1 idx=2", valid, {x, y, z});
        else n_pass++;
        n = 1;
        for (int i = 0; i < 10 && valid; i++) begin
            tick();
            if (valid) n++;
        end
        n_checks++;
        if (n != MAX_HOLD || timeout !== 1'b1) $display("FAIL timeout_len: got len=%0d timeout=%b expected len=%0d timeout=1", n, timeout, MAX_HOLD);
        else n_pass++;
        tick();
        n_checks++;
        if (timeout !== 1'b0 || valid !== 1'b0) $display("FAIL timeout_pulse: got timeout=%b valid=%b expected 0 0", timeout, valid);
        else n_pass++;
        tick();
        n_checks++;
        if ({x, y, z, valid} !== 4'b0101) $display("FAIL timeout_regrant: got xyz/v=%b expected 0101", {x, y, z, valid});
        else n_pass++;
        req = 8'h00;
        tick(); tick();
    endtask

    task automatic test_withdraw();
        bit ok;
        req = 8'h20;
        wait_valid(ok);
        n_checks++;
        if (!ok || {x, y, z} !== 3'd5) $display("FAIL withdraw_grant: got valid=%b idx=%0d expected valid=1 idx=5", valid, {x, y, z});
        else n_pass++;
        tick();
        req = 8'h00;
        tick();
        n_checks++;
        if ({x, y, z, valid, timeout} !== 5'b10100) $display("FAIL withdraw_release: got %b expected 10100", {x, y, z, valid, timeout});
        else n_pass++;
        tick(); tick();
        n_checks++;
        if ({x, y, z, valid, timeout} !== 5'b10100) $display("FAIL withdraw_idle_hold: got %b expected 10100", {x, y, z, valid, timeout});
        else n_pass++;
    endtask

    task automatic test_done_with_timeout();
        bit ok;
        req = 8'h08;
        wait_valid(ok);
        tick(); tick(); tick();
        n_checks++;
        if (!ok || valid !== 1'b1 || {x, y, z} !== 3'd3) $display("FAIL done_to_hold: got valid=%b idx=%0d expected valid=1 idx=3", valid, {x, y, z});
        else n_pass++;
        done = 1'b1;
        tick();
        done = 1'b0;
        n_checks++;
        if (valid !== 1'b0 || timeout !== 1'b0) $display("FAIL done_over_timeout: got valid=%b timeout=%b expected 0 0", valid, timeout);
        else n_pass++;
        req = 8'h00;
        tick(); tick();
    endtask

    task automatic test_reset_mid_grant();
        bit ok;
        req = 8'h40;
        wait_valid(ok);
        n_checks++;
        if (!ok || {x, y, z} !== 3'd6) $display("FAIL rst_mid_grant: got valid=%b idx=%0d expected valid=1 idx=6", valid, {x, y, z});
        else n_pass++;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_checks++;
        if ({x, y, z, valid} !== 4'b0000) $display("FAIL rst_mid_clear: got xyz/v=%b expected 0000", {x, y, z, valid});
        else n_pass++;
        req = 8'hC0;
        tick();
        n_checks++;
        if ({x, y, z, valid} !== 4'b1101) $display("FAIL rst_ptr: got xyz/v=%b expected 1101", {x, y, z, valid});
        else n_pass++;
        req = 8'h00;
        tick(); tick();
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 3) == 0) req = 8'($urandom) & 8'($urandom);
            done = ($urandom_range(0, 5) == 0);
            rst  = ($urandom_range(0, 199) == 0);
            tick();
            n_checks++;
            if ({x, y, z, valid, timeout} !== {m_sel, m_valid, m_to})
                $display("FAIL random_cycle%0d: got xyz/v/t=%b expected %b", i, {x, y, z, valid, timeout}, {m_sel, m_valid, m_to});
            else n_pass++;
        end
        rst = 1'b0; done = 1'b0; req = 8'h00;
    endtask

    initial begin
        test_reset();
        test_first_grant();
        test_rotation();
        test_timeout();
        test_withdraw();
        test_done_with_timeout();
        test_reset_mid_grant();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
